// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half_adder cell.
//   CNT_W    : width of the carry-event counter
//   CNT_MAX  : saturation value of the carry-event counter
//   PIPE_MAX : deepest supported pipeline
package half_adder_pkg;

    localparam int unsigned CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
    localparam int unsigned PIPE_MAX = 4;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/half_adder_stage.sv
// One pipeline stage of the half_adder: a valid bit plus a data register
// that loads only when the incoming valid is set, otherwise holds.
//   clk, rst_n  : clock, asynchronous active-low reset
//   prev_valid  : valid from the previous stage
//   prev_data   : data from the previous stage
//   valid       : registered valid
//   data        : registered data (holds last valid payload)
module half_adder_stage #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         prev_valid,
    input  logic [W-1:0] prev_data,
    output logic         valid,
    output logic [W-1:0] data
);

    // Valid follows every cycle; data is gated so idle-cycle garbage never loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/half_adder.sv
// Registered adder cell: {c,s} = a + b + (HAS_CIN ? c_in : 0), delivered
// PIPE cycles after a valid input, plus a saturating count of carry-outs.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : a/b/c_in qualify this cycle
//   a, b         : WIDTH-bit operands
//   c_in         : carry-in (ignored when HAS_CIN=0)
//   out_valid    : s/c carry a new result this cycle
//   s, c         : sum and carry-out
//   carry_count  : saturating count of valid results with c=1
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned PIPE    = 1,
    parameter bit          HAS_CIN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic [CNT_W-1:0] carry_count
);

    localparam int unsigned DW = WIDTH + 1;

    // Elaboration-time parameter range checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("half_adder: WIDTH must be 1..32");
    end
    if (PIPE < 1 || PIPE > PIPE_MAX) begin : g_bad_pipe
        $error("half_adder: PIPE must be 1..PIPE_MAX");
    end

    logic          cin_eff_c;
    logic [DW-1:0] sum_c;

    // Zero-extended add; the extra bit is the carry-out.
    always_comb begin
        cin_eff_c = HAS_CIN ? c_in : 1'b0;
        sum_c     = DW'(a) + DW'(b) + DW'(cin_eff_c);
    end

    logic [PIPE:0] vld;
    logic [DW-1:0] dat [PIPE+1];

    assign vld[0] = in_valid;
    assign dat[0] = sum_c;

    // Pipeline of valid-gated stages.
    for (genvar i = 0; i < PIPE; i++) begin : g_stage
        half_adder_stage #(
            .W (DW)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (vld[i]),
            .prev_data  (dat[i]),
            .valid      (vld[i+1]),
            .data       (dat[i+1])
        );
    end

    assign out_valid = vld[PIPE];
    assign {c, s}    = dat[PIPE];

    // Count presented results that carried out; sticks at CNT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_count <= '0;
        end else if (out_valid && c) begin
            carry_count <= sat_inc(carry_count);
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: three configurations share one stimulus
// stream; each has its own expected-result queue and monitor.
//   A: WIDTH=1 PIPE=1 HAS_CIN=1   B: WIDTH=4 PIPE=3 HAS_CIN=1
//   C: WIDTH=1 PIPE=2 HAS_CIN=0
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid;
    logic [3:0] a, b;
    logic       c_in;

    logic        va, vb, vc;
    logic [0:0]  sa, sc;
    logic [3:0]  sb;
    logic        ca, cb, cc;
    logic [15:0] cnta, cntb, cntc;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(1), .PIPE(1), .HAS_CIN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
        .c_in(c_in), .out_valid(va), .s(sa), .c(ca), .carry_count(cnta));

    half_adder #(.WIDTH(4), .PIPE(3), .HAS_CIN(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .c_in(c_in), .out_valid(vb), .s(sb), .c(cb), .carry_count(cntb));

    half_adder #(.WIDTH(1), .PIPE(2), .HAS_CIN(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
        .c_in(c_in), .out_valid(vc), .s(sc), .c(cc), .carry_count(cntc));

    int checks = 0;
    int failures = 0;

    // Expected results as {c, s[3:0]}.
    logic [4:0] qa[$], qb[$], qc[$];
    logic [4:0] last_a = '0, last_b = '0, last_c = '0;
    logic [4:0] ea, eb, ec;
    int         cnt_a = 0, cnt_b = 0, cnt_c = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the masked operands.
    function automatic logic [4:0] ref_sum(input int w, input bit hc,
                                           input logic [3:0] av, input logic [3:0] bv,
                                           input logic ci);
        int m, t;
        m = (1 << w) - 1;
        t = (int'(av) & m) + (int'(bv) & m) + ((hc && ci === 1'b1) ? 1 : 0);
        return {1'((t >> w) & 1), 4'(t & m)};
    endfunction

    task automatic drive(input bit v, input logic [3:0] av, input logic [3:0] bv, input logic ci);
        @(posedge clk);
        #1;
        in_valid = v;
        a = av;
        b = bv;
        c_in = ci;
        if (v) begin
            qa.push_back(ref_sum(1, 1'b1, av, bv, ci));
            qb.push_back(ref_sum(4, 1'b1, av, bv, ci));
            qc.push_back(ref_sum(1, 1'b0, av, bv, ci));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_va"}, 32'(va), 0);   chk({tag, "_sa"}, 32'(sa), 0);
        chk({tag, "_ca"}, 32'(ca), 0);   chk({tag, "_cnta"}, 32'(cnta), 0);
        chk({tag, "_vb"}, 32'(vb), 0);   chk({tag, "_sb"}, 32'(sb), 0);
        chk({tag, "_cb"}, 32'(cb), 0);   chk({tag, "_cntb"}, 32'(cntb), 0);
        chk({tag, "_vc"}, 32'(vc), 0);   chk({tag, "_sc"}, 32'(sc), 0);
        chk({tag, "_cc"}, 32'(cc), 0);   chk({tag, "_cntc"}, 32'(cntc), 0);
    endtask

    // Monitors: counter checked against events seen on earlier cycles.
    always @(negedge clk) if (rst_n) begin
        chk("A_cnt", 32'(cnta), 32'(cnt_a));
        if (va) begin
            if (qa.size() == 0) chk("A_unexpected_valid", 32'(va), 0);
            else begin
                ea = qa.pop_front();
                chk("A_s", 32'(sa), 32'(ea[0]));
                chk("A_c", 32'(ca), 32'(ea[4]));
                last_a = ea;
                if (ea[4] && cnt_a < 65535) cnt_a++;
            end
        end else begin
            chk("A_hold_s", 32'(sa), 32'(last_a[0]));
            chk("A_hold_c", 32'(ca), 32'(last_a[4]));
        end
    end

    always @(negedge clk) if (rst_n) begin
        chk("B_cnt", 32'(cntb), 32'(cnt_b));
        if (vb) begin
            if (qb.size() == 0) chk("B_unexpected_valid", 32'(vb), 0);
            else begin
                eb = qb.pop_front();
                chk("B_s", 32'(sb), 32'(eb[3:0]));
                chk("B_c", 32'(cb), 32'(eb[4]));
                last_b = eb;
                if (eb[4] && cnt_b < 65535) cnt_b++;
            end
        end else begin
            chk("B_hold_s", 32'(sb), 32'(last_b[3:0]));
            chk("B_hold_c", 32'(cb), 32'(last_b[4]));
        end
    end

    always @(negedge clk) if (rst_n) begin
        chk("C_cnt", 32'(cntc), 32'(cnt_c));
        if (vc) begin
            if (qc.size() == 0) chk("C_unexpected_valid", 32'(vc), 0);
            else begin
                ec = qc.pop_front();
                chk("C_s", 32'(sc), 32'(ec[0]));
                chk("C_c", 32'(cc), 32'(ec[4]));
                last_c = ec;
                if (ec[4] && cnt_c < 65535) cnt_c++;
            end
        end else begin
            chk("C_hold_s", 32'(sc), 32'(last_c[0]));
            chk("C_hold_c", 32'(cc), 32'(last_c[4]));
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        in_valid = 1'b0; a = 4'h0; b = 4'h0; c_in = 1'b0;
        #3;
        chk_zero("reset");
        #9;
        rst_n = 1'b1;

        // All eight (a,b,c_in) combinations back-to-back.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v3;
            v3 = 3'(i);
            drive(1'b1, {3'b0, v3[2]}, {3'b0, v3[1]}, v3[0]);
        end
        idle(3);

        // Carry-in ignored in C; 4-bit wrap with carry in B, then hold.
        drive(1'b1, 4'h1, 4'h1, 1'b1);
        drive(1'b1, 4'h1, 4'h0, 1'b1);
        drive(1'b1, 4'hF, 4'h1, 1'b1);
        idle(5);

        // Idle inputs driven to X must not reach the outputs.
        for (int i = 0; i < 5; i++) drive(1'b0, 4'hx, 4'hx, 1'bx);

        // Random traffic with random valid gaps.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 1'($urandom));
        idle(6);

        // Reset with two samples in flight in the deep pipe.
        drive(1'b1, 4'h7, 4'h9, 1'b1);
        drive(1'b1, 4'hF, 4'hF, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_zero("midreset");
        qa.delete(); qb.delete(); qc.delete();
        last_a = '0; last_b = '0; last_c = '0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 100; i++)
            drive($urandom_range(0, 1) != 0, 4'($urandom), 4'($urandom), 1'($urandom));

        // Carry every cycle long enough to saturate the counters.
        for (int i = 0; i < 65540; i++) drive(1'b1, 4'hF, 4'h1, 1'b1);
        idle(6);
        chk("A_cnt_sat", 32'(cnta), 32'hFFFF);
        chk("B_cnt_sat", 32'(cntb), 32'hFFFF);
        chk("C_cnt_sat", 32'(cntc), 32'hFFFF);

        chk("A_drained", 32'(qa.size()), 0);
        chk("B_drained", 32'(qb.size()), 0);
        chk("C_drained", 32'(qc.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
